imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Fetch sequencer between the pipeline front end and the combinational 32-bit instruction ROM (byte-addressed, word-aligned).
- Owns the fetch PC and drives the ROM address.
- Captures each fetched word with its PC into a small prefetch FIFO and hands it to decode over a valid/ready handshake.
- Handles branch redirect, halt requests, and alignment/bounds faults, so the ROM never sees an illegal address.

Parameters:
- MEM_SIZE, 1024, instruction ROM size in bytes; power of two, greater than 4.
- RESET_PC, 0, fetch PC loaded on reset; must be word-aligned.
- DEPTH, 2, prefetch FIFO entries; at least 1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  64  byte address to the instruction ROM; combinational.
- imem_instr  in  32  ROM read data; combinational from imem_addr.
- redirect_valid  in  1  branch/exception redirect this cycle.
- redirect_pc  in  64  redirect target address.
- halt_req  in  1  level request to stop fetching.
- out_valid  out  1  FIFO head valid.
- out_instr  out  32  FIFO head instruction.
- out_pc  out  64  FIFO head PC.
- out_ready  in  1  decode accepts the head.
- fault  out  1  sticky fetch fault flag.
- fault_pc  out  64  PC that faulted.
- state  out  2  encoding: 0 RUN, 1 HALT, 2 FAULT.

Behaviour:
- Reset, async, while asserted:
  - fetch_pc = RESET_PC; FIFO empty.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - fault = 0, fault_pc = 0, state = RUN.
  - imem_addr = 0.
  - Reset asserted mid-operation discards all in-flight contents immediately.
- pop = out_valid & out_ready.
- bad = (fetch_pc[1:0] != 0) | (fetch_pc + 3 >= MEM_SIZE), evaluated with 64-bit unsigned arithmetic.
- fetch_en = (state == RUN) & !redirect_valid & !bad & (count < DEPTH | pop).
- imem_addr = fetch_pc when fetch_en, else 0. The ROM is therefore only ever addressed legally.
- On posedge, when fetch_en:
  - push {imem_instr, fetch_pc} at the FIFO tail;
  - fetch_pc <= fetch_pc + 4.
  - Fetch latency: a word fetched in cycle N is visible at out_* in cycle N+1.
- Full FIFO with a pop in the same cycle: push and pop both occur, count is unchanged. Full without a pop: no fetch, fetch_pc holds.
- Empty FIFO: out_valid = 0, and out_instr/out_pc hold their last values. Simultaneous push and pop on an empty FIFO cannot occur, because out_valid = 0.
- Redirect has the highest priority, in any state:
  - flush the FIFO (a pop in that cycle is still considered consumed);
  - fetch_pc <= redirect_pc; no push that cycle.
  - From FAULT: state <= RUN, fault <= 0.
  - From HALT: stay in HALT.
  - From RUN: stay in RUN.
  - The target is validated on the next fetch attempt.
- RUN -> FAULT when state == RUN, !redirect_valid, and bad:
  - fault <= 1, fault_pc <= fetch_pc; no push; fetch_pc holds.
  - This takes priority over halt_req in the same cycle.
- RUN -> HALT when halt_req = 1 and no fault/redirect. The fetch in that same cycle still occurs if fetch_en.
- HALT -> RUN when halt_req = 0.
- FAULT exits only via redirect or reset; halt_req is ignored in FAULT.
- The FIFO keeps draining through out_* in HALT and FAULT; pop is always honoured.
- out_* are stable while out_valid = 1 and out_ready = 0.

Test Plan:
- Reset release, out_ready = 1, ROM words 0..3 = A, B, C, D -> imem_addr 0, 4, 8, 12 on consecutive cycles; out_pc 0, 4, 8, 12 with out_instr A–D starting one cycle after each fetch.
- out_ready = 0 from reset -> exactly DEPTH = 2 pushes (PC 0, 4), then imem_addr = 0 and fetch_pc frozen at 8. Raising out_ready -> A, B, C delivered in order with no gaps.
- Redirect to 0x40 while the FIFO holds PC 8 and 12 -> out_valid = 0 the next cycle; next fetch at 0x40; out_pc = 0x40 one cycle after that; PC 8/12 are never delivered.
- Redirect to 0x3FE -> state = FAULT, fault = 1, fault_pc = 0x3FE, imem_addr = 0. Redirect to 0x3FC -> state = RUN, fault = 0, word at 0x3FC delivered. Sequential fetch to 0x400 -> FAULT with fault_pc = 0x400.
- halt_req held for 5 cycles with out_ready = 1 -> state = HALT, FIFO drains to empty, no new fetches. Releasing halt_req -> RUN, fetch resumes at the held fetch_pc.
- Reset asserted asynchronously mid-stream (FIFO full, state HALT) -> all outputs take their reset values without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, addresses the ROM only at legal
// word addresses, and queues {instr, pc} pairs in a small FIFO towards decode.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = '0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [1:0]  state
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;
  localparam logic [63:0]   MEM_BYTES = 64'(MEM_SIZE);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]    state_q, state_d;
  logic          fault_q, fault_d;
  logic [63:0]   fault_pc_q, fault_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hold_instr_q;
  logic [63:0]   hold_pc_q;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [63:0]   fifo_pc_q    [DEPTH];

  logic pop, bad, fetch_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign pop      = (count_q != '0) & out_ready;
  assign bad      = (fetch_pc_q[1:0] != 2'b00) | ((fetch_pc_q + 64'd3) >= MEM_BYTES);
  // Gated by reset so the ROM sees address 0 while reset is held.
  assign fetch_en = !reset & (state_q == ST_RUN) & !redirect_valid & !bad &
                    ((count_q < DEPTH_C) | pop);

  assign imem_addr = fetch_en ? fetch_pc_q : '0;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : hold_instr_q;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : hold_pc_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign state     = state_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (state_q == ST_FAULT) begin
        state_d = ST_RUN;
        fault_d = 1'b0;
      end
    end else begin
      if (fetch_en) begin
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(fetch_en) - CW'(pop);
      case (state_q)
        ST_RUN: begin
          if (bad) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = fetch_pc_q;
          end else if (halt_req) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: if (!halt_req) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      state_q      <= ST_RUN;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      state_q    <= state_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      // Shadow of the current head so out_* hold their last value once the FIFO empties.
      if (out_valid) begin
        hold_instr_q <= fifo_instr_q[rd_ptr_q];
        hold_pc_q    <= fifo_pc_q[rd_ptr_q];
      end
      if (fetch_en) begin
        fifo_instr_q[wr_ptr_q] <= imem_instr;
        fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch rules.
module tb_imem_fetch_ctrl;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        fault;
  logic [63:0] fault_pc;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [256];
  assign imem_instr = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'd0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .fault(fault), .fault_pc(fault_pc), .state(state)
  );

  typedef struct { logic [31:0] instr; logic [63:0] pc; } entry_t;
  entry_t      m_q[$];
  logic [63:0] m_pc, m_fpc, m_lp;
  logic [31:0] m_li;
  int          m_state;
  bit          m_fault;

  task automatic drive(input bit rdy, input bit rv, input logic [63:0] rpc, input bit h);
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 64'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_q.delete(); m_pc = 0; m_fpc = 0; m_lp = 0; m_li = 0; m_state = 0; m_fault = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 64'd0, 0);
    #1;
    checks++;
    if ({imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state} !== '0) begin
      failures++;
      $display("FAIL reset_async addr=%h v=%b i=%h pc=%h f=%b fpc=%h st=%0d exp all zero",
               imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state);
    end
    @(posedge clk); #1;
    checks++;
    if ({imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state} !== '0) begin
      failures++;
      $display("FAIL reset_held addr=%h v=%b i=%h pc=%h f=%b fpc=%h st=%0d exp all zero",
               imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 64'd0, 0);
      @(negedge clk);
      checks++;
      if (imem_addr !== 64'(4 * k)) begin
        failures++;
        $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr, 64'(4 * k));
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'(4 * (k - 1)) || out_instr !== rom[k - 1]) begin
          failures++;
          $display("FAIL stream_out k=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                   k, out_valid, out_pc, out_instr, 64'(4 * (k - 1)), rom[k - 1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_addr [5] = '{64'd0, 64'd4, 64'd0, 64'd0, 64'd0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 64'd0, 0);
      @(negedge clk);
      checks++;
      if (imem_addr !== exp_addr[k]) begin
        failures++;
        $display("FAIL bp_stall_addr k=%0d got=%h exp=%h", k, imem_addr, exp_addr[k]);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 64'd0, 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== rom[k] ||
          imem_addr !== 64'(8 + 4 * k)) begin
        failures++;
        $display("FAIL bp_drain k=%0d got v=%b pc=%h i=%h addr=%h exp v=1 pc=%h i=%h addr=%h",
                 k, out_valid, out_pc, out_instr, imem_addr, 64'(4 * k), rom[k], 64'(8 + 4 * k));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(k >= 2, 0, 64'd0, 0);
      @(posedge clk); #1;
    end
    drive(0, 1, 64'h40, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'd8 || imem_addr !== 64'd0) begin
      failures++;
      $display("FAIL redir_pre got v=%b pc=%h addr=%h exp v=1 pc=8 addr=0", out_valid, out_pc, imem_addr);
    end
    @(posedge clk); #1;
    drive(1, 0, 64'd0, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
      failures++;
      $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=40", out_valid, imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(64 + 4 * k) || out_instr !== rom[16 + k]) begin
        failures++;
        $display("FAIL redir_target k=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 k, out_valid, out_pc, out_instr, 64'(64 + 4 * k), rom[16 + k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fault();
    do_reset();
    drive(1, 1, 64'h3FE, 0);
    @(posedge clk); #1;
    drive(1, 0, 64'd0, 0);
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL fault_misaligned_addr got addr=%h st=%0d exp addr=0 st=0", imem_addr, state);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive(1, 0, 64'd0, 1);
      @(negedge clk);
      checks++;
      if (state !== 2'd2 || fault !== 1'b1 || fault_pc !== 64'h3FE || imem_addr !== 64'd0) begin
        failures++;
        $display("FAIL fault_entry k=%0d got st=%0d f=%b fpc=%h addr=%h exp st=2 f=1 fpc=3fe addr=0",
                 k, state, fault, fault_pc, imem_addr);
      end
    end
    @(posedge clk); #1;
    drive(1, 1, 64'h3FC, 0);
    @(posedge clk); #1;
    drive(1, 0, 64'd0, 0);
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || fault !== 1'b0 || imem_addr !== 64'h3FC) begin
      failures++;
      $display("FAIL fault_recover got st=%0d f=%b addr=%h exp st=0 f=0 addr=3fc", state, fault, imem_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3FC || out_instr !== rom[255] || imem_addr !== 64'd0) begin
      failures++;
      $display("FAIL fault_lastword got v=%b pc=%h i=%h addr=%h exp v=1 pc=3fc i=%h addr=0",
               out_valid, out_pc, out_instr, imem_addr, rom[255]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || fault !== 1'b1 || fault_pc !== 64'h400) begin
      failures++;
      $display("FAIL fault_bounds got st=%0d f=%b fpc=%h exp st=2 f=1 fpc=400", state, fault, fault_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 64'd0, 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 64'd0, 1);
      @(negedge clk);
      checks++;
      if (k == 0) begin
        if (imem_addr !== 64'd12 || state !== 2'd0) begin
          failures++;
          $display("FAIL halt_last_fetch got addr=%h st=%0d exp addr=c st=0", imem_addr, state);
        end
      end else if (imem_addr !== 64'd0 || state !== 2'd1 || out_pc !== 64'd12 ||
                   out_valid !== (k == 1)) begin
        failures++;
        $display("FAIL halt_drain k=%0d got addr=%h st=%0d v=%b pc=%h exp addr=0 st=1 v=%b pc=c",
                 k, imem_addr, state, out_valid, out_pc, k == 1);
      end
      @(posedge clk); #1;
    end
    drive(1, 0, 64'd0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || imem_addr !== 64'd16) begin
      failures++;
      $display("FAIL halt_resume got st=%0d addr=%h exp st=0 addr=10", state, imem_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 64'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 0, 64'd0, 1);
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd1 || out_valid !== 1'b1 || out_pc !== 64'd0) begin
      failures++;
      $display("FAIL arst_pre got st=%0d v=%b pc=%h exp st=1 v=1 pc=0", state, out_valid, out_pc);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state} !== '0) begin
      failures++;
      $display("FAIL arst_mid addr=%h v=%b i=%h pc=%h f=%b fpc=%h st=%0d exp all zero",
               imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 0, 64'd0, 0);
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'd0 || state !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_restart got addr=%h st=%0d v=%b exp addr=0 st=0 v=0", imem_addr, state, out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'd4 || out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== rom[0]) begin
      failures++;
      $display("FAIL arst_second got addr=%h v=%b pc=%h i=%h exp addr=4 v=1 pc=0 i=%h",
               imem_addr, out_valid, out_pc, out_instr, rom[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          rdy, rv, h, m_pop, m_bad, m_fen;
    logic [63:0] rpc, e_addr, e_pc;
    logic [31:0] e_instr;
    bit          e_valid;
    do_reset();
    h = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       rpc = 64'($urandom_range(0, 255)) * 64'd4;
        1:       rpc = 64'($urandom_range(0, 1023));
        2:       rpc = 64'h3F0 + 64'($urandom_range(0, 6)) * 64'd4;
        default: rpc = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 99) < 15) h = !h;
      drive(rdy, rv, rpc, h);
      @(negedge clk);
      m_bad   = (m_pc[1:0] != 2'b00) || ((m_pc + 64'd3) >= 64'd1024);
      e_valid = (m_q.size() > 0);
      m_pop   = e_valid && rdy;
      m_fen   = (m_state == 0) && !rv && !m_bad && ((m_q.size() < DEPTH) || m_pop);
      e_addr  = m_fen ? m_pc : 64'd0;
      e_instr = e_valid ? m_q[0].instr : m_li;
      e_pc    = e_valid ? m_q[0].pc : m_lp;
      checks++;
      if ({imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state} !==
          {e_addr, e_valid, e_instr, e_pc, m_fault, m_fpc, 2'(m_state)}) begin
        failures++;
        $display("FAIL rand cyc=%0d got addr=%h v=%b i=%h pc=%h f=%b fpc=%h st=%0d exp addr=%h v=%b i=%h pc=%h f=%b fpc=%h st=%0d",
                 cyc, imem_addr, out_valid, out_instr, out_pc, fault, fault_pc, state,
                 e_addr, e_valid, e_instr, e_pc, m_fault, m_fpc, m_state);
      end
      if (e_valid) begin m_li = m_q[0].instr; m_lp = m_q[0].pc; end
      if (m_pop) void'(m_q.pop_front());
      if (rv) begin
        m_q.delete();
        m_pc = rpc;
        if (m_state == 2) begin m_state = 0; m_fault = 0; end
      end else begin
        if (m_fen) begin
          m_q.push_back('{rom[m_pc[9:2]], m_pc});
          m_pc = m_pc + 64'd4;
        end
        if (m_state == 0) begin
          if (m_bad) begin m_state = 2; m_fault = 1; m_fpc = m_pc; end
          else if (h) m_state = 1;
        end else if (m_state == 1 && !h) begin
          m_state = 0;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
